// File: rtl/tboard_pkg.sv
// Shared types and encodings for the N x N game board.
package tboard_pkg;

    typedef enum logic [1:0] {
        PLAY,
        CHECK,
        DONE
    } state_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_O    = 2'b01;
    localparam logic [1:0] W_X    = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    localparam logic SYM_X = 1'b1;
    localparam logic SYM_O = 1'b0;

    // Line l of an n x n board: rows 0..n-1, columns n..2n-1,
    // then the main diagonal and the anti-diagonal.
    function automatic logic [63:0] line_mask(input int n, input int l);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < n; i++) begin
            if (l < n)
                m[l*n+i] = 1'b1;
            else if (l < 2 * n)
                m[i*n+(l-n)] = 1'b1;
            else if (l == 2 * n)
                m[i*n+i] = 1'b1;
            else
                m[i*n+(n-1-i)] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/tboard_if.sv
// Move request handshake between the input decoder and the board.
interface tboard_if #(
    parameter int N = 3
);
    localparam int CW = $clog2(N);

    logic          move_valid;
    logic [CW-1:0] move_row;
    logic [CW-1:0] move_col;
    logic          move_ready;
    logic          move_ok;
    logic          move_err;

    modport master (
        output move_valid, move_row, move_col,
        input  move_ready, move_ok, move_err
    );

    modport slave (
        input  move_valid, move_row, move_col,
        output move_ready, move_ok, move_err
    );

endinterface

// File: rtl/tboard_win_detect.sv
// Combinational N-in-a-row detector over all 2N+2 lines for one player.
module tboard_win_detect
    import tboard_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N*N-1:0] valid,
    input  logic [N*N-1:0] symbol,
    input  logic           player,
    output logic           win,
    output logic [N*N-1:0] win_mask
);
    localparam int NL = 2 * N + 2;

    logic [N*N-1:0] own;
    logic [NL-1:0]  hit;
    logic [N*N-1:0] hit_mask [NL];

    assign own = valid & (player == SYM_X ? symbol : ~symbol);

    for (genvar l = 0; l < NL; l++) begin : g_line
        localparam logic [63:0] M = line_mask(N, l);
        logic [N*N-1:0] m;
        assign m           = M[N*N-1:0];
        assign hit[l]      = (own & m) == m;
        assign hit_mask[l] = hit[l] ? m : '0;
    end

    always_comb begin
        win_mask = '0;
        for (int l = 0; l < NL; l++)
            win_mask = win_mask | hit_mask[l];
    end

    assign win = |hit;

endmodule

// File: rtl/tboard_game.sv
// N x N board with move handshake, X/O alternation and result FSM.
module tboard_game
    import tboard_pkg::*;
#(
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           new_game,
    tboard_if.slave        mv,
    output logic [N*N-1:0] valid,
    output logic [N*N-1:0] symbol,
    output logic           turn,
    output logic           game_over,
    output logic [1:0]     winner,
    output logic [N*N-1:0] win_mask
);
    localparam int NN = N * N;
    localparam int CW = $clog2(N);
    localparam int IW = $clog2(NN);
    localparam int KW = $clog2(NN + 1);

    state_t         state, state_nx;
    logic [KW-1:0]  count;
    logic           ok_q, err_q, ready;
    logic [IW-1:0]  idx;
    logic [NN-1:0]  onehot;
    logic           in_range, legal, take, full;
    logic           det_win;
    logic [NN-1:0]  det_mask;

    assign in_range = ({1'b0, mv.move_row} < (CW + 1)'(N))
                   && ({1'b0, mv.move_col} < (CW + 1)'(N));
    assign idx      = IW'(mv.move_row) * IW'(N) + IW'(mv.move_col);
    assign onehot   = NN'(1) << idx;
    // onehot may alias a real cell when out of range, so gate it
    assign legal    = in_range && !(|(valid & onehot));
    assign take     = mv.move_valid && state == PLAY;
    assign full     = count == KW'(NN);

    tboard_win_detect #(.N(N)) u_win (
        .valid    (valid),
        .symbol   (symbol),
        .player   (turn),
        .win      (det_win),
        .win_mask (det_mask)
    );

    always_comb begin
        state_nx  = state;
        ready     = 1'b0;
        game_over = 1'b0;
        unique case (state)
            PLAY: begin
                ready = 1'b1;
                if (take && legal)
                    state_nx = CHECK;
            end
            CHECK: begin
                if (det_win || full)
                    state_nx = DONE;
                else
                    state_nx = PLAY;
            end
            DONE:    game_over = 1'b1;
            default: state_nx = PLAY;
        endcase
        if (new_game)
            state_nx = PLAY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= PLAY;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid    <= '0;
            symbol   <= '0;
            turn     <= SYM_X;
            count    <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            winner   <= W_NONE;
            win_mask <= '0;
        end else if (new_game) begin
            valid    <= '0;
            symbol   <= '0;
            turn     <= SYM_X;
            count    <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            winner   <= W_NONE;
            win_mask <= '0;
        end else begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            unique case (state)
                PLAY: begin
                    if (take && legal) begin
                        valid  <= valid | onehot;
                        symbol <= (symbol & ~onehot)
                                | (turn == SYM_X ? onehot : '0);
                        count  <= count + KW'(1);
                        ok_q   <= 1'b1;
                    end else if (take) begin
                        err_q <= 1'b1;
                    end
                end
                CHECK: begin
                    if (det_win) begin
                        winner   <= (turn == SYM_X) ? W_X : W_O;
                        win_mask <= det_mask;
                    end else if (full) begin
                        winner <= W_DRAW;
                    end else begin
                        turn <= ~turn;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mv.move_ready = ready;
    assign mv.move_ok    = ok_q;
    assign mv.move_err   = err_q;

endmodule

// File: tb/tb_tboard_game.sv
// Scoreboard bench: randomized and directed games against a board model.
module tb_tboard_game;
    localparam int N  = 3;
    localparam int NN = N * N;

    logic clk = 1'b0;
    logic reset, ng3, ng4;
    logic [NN-1:0] valid3, symbol3, mask3;
    logic          turn3, over3;
    logic [1:0]    win3;
    logic [15:0]   valid4, symbol4, mask4;
    logic          turn4, over4;
    logic [1:0]    win4;

    always #5 clk = ~clk;

    tboard_if #(.N(3)) m3 ();
    tboard_if #(.N(4)) m4 ();

    tboard_game #(.N(3)) dut3 (
        .clk(clk), .reset(reset), .new_game(ng3), .mv(m3),
        .valid(valid3), .symbol(symbol3), .turn(turn3),
        .game_over(over3), .winner(win3), .win_mask(mask3)
    );

    tboard_game #(.N(4)) dut4 (
        .clk(clk), .reset(reset), .new_game(ng4), .mv(m4),
        .valid(valid4), .symbol(symbol4), .turn(turn4),
        .game_over(over4), .winner(win4), .win_mask(mask4)
    );

    typedef struct {
        bit            ok;
        logic [NN-1:0] vld;
        logic [NN-1:0] sym;
        bit            turn;
        bit            over;
        logic [1:0]    win;
        logic [NN-1:0] mask;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Model board: 0 empty, 1 X, 2 O
    int            brd [N][N];
    bit            m_turn;
    int            m_count;
    bit            m_over;
    logic [1:0]    m_win;
    logic [NN-1:0] m_mask;
    bit            last_ok;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                brd[r][c] = 0;
        m_turn  = 1'b1;
        m_count = 0;
        m_over  = 1'b0;
        m_win   = 2'b00;
        m_mask  = '0;
    endfunction

    function automatic exp_t model_move(int r, int c);
        exp_t          e;
        int            p;
        logic [NN-1:0] won;
        p    = m_turn ? 1 : 2;
        won  = '0;
        e.ok = 1'b0;
        if (r < N && c < N && brd[r][c] == 0) begin
            e.ok = 1'b1;
            brd[r][c] = p;
            m_count++;
            for (int l = 0; l < 2 * N + 2; l++) begin
                logic [NN-1:0] lm;
                bit            all;
                lm  = '0;
                all = 1'b1;
                for (int i = 0; i < N; i++) begin
                    int rr, cc;
                    rr = (l < N) ? l : i;
                    cc = (l < N) ? i : (l < 2 * N) ? l - N
                       : (l == 2 * N) ? i : N - 1 - i;
                    lm[rr*N+cc] = 1'b1;
                    if (brd[rr][cc] != p) all = 1'b0;
                end
                if (all) won |= lm;
            end
            if (won != 0) begin
                m_over = 1'b1;
                m_win  = (p == 1) ? 2'b10 : 2'b01;
                m_mask = won;
            end else if (m_count == NN) begin
                m_over = 1'b1;
                m_win  = 2'b11;
            end else begin
                m_turn = !m_turn;
            end
        end
        for (int rr = 0; rr < N; rr++)
            for (int cc = 0; cc < N; cc++) begin
                e.vld[rr*N+cc] = (brd[rr][cc] != 0);
                e.sym[rr*N+cc] = (brd[rr][cc] == 1);
            end
        e.turn = m_turn;
        e.over = m_over;
        e.win  = m_win;
        e.mask = m_mask;
        return e;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (m3.move_ready !== 1'b1 && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        if (m3.move_ready !== 1'b1)
            check("ready_timeout", 32'(m3.move_ready), 32'd1);
    endtask

    task automatic play(input int r, input int c);
        exp_t e;
        wait_ready();
        e = model_move(r, c);
        last_ok = e.ok;
        sbq.push_back(e);
        m3.move_valid = 1'b1;
        m3.move_row   = 2'(r);
        m3.move_col   = 2'(c);
        @(posedge clk); #1;
        m3.move_valid = 1'b0;
    endtask

    task automatic poke(input int r, input int c);
        m3.move_valid = 1'b1;
        m3.move_row   = 2'(r);
        m3.move_col   = 2'(c);
        @(posedge clk); #1;
        m3.move_valid = 1'b0;
        check("ignored_ok", 32'(m3.move_ok), 32'd0);
        check("ignored_err", 32'(m3.move_err), 32'd0);
    endtask

    task automatic check_idle(string tag);
        check({tag, "_valid"}, 32'(valid3), 32'd0);
        check({tag, "_turn"}, 32'(turn3), 32'd1);
        check({tag, "_winner"}, 32'(win3), 32'd0);
        check({tag, "_mask"}, 32'(mask3), 32'd0);
        check({tag, "_over"}, 32'(over3), 32'd0);
        check({tag, "_ok"}, 32'(m3.move_ok), 32'd0);
        check({tag, "_err"}, 32'(m3.move_err), 32'd0);
        check({tag, "_ready"}, 32'(m3.move_ready), 32'd1);
    endtask

    task automatic start_new(input bit with_move);
        @(posedge clk); #1;
        ng3           = 1'b1;
        m3.move_valid = with_move;
        m3.move_row   = 2'($urandom_range(0, 3));
        m3.move_col   = 2'($urandom_range(0, 3));
        @(posedge clk); #1;
        ng3           = 1'b0;
        m3.move_valid = 1'b0;
        model_clear();
        check_idle("newgame");
    endtask

    task automatic check_done();
        check("done_over", 32'(over3), 32'(m_over));
        check("done_winner", 32'(win3), 32'(m_win));
        check("done_mask", 32'(mask3), 32'(m_mask));
        check("done_ready", 32'(m3.move_ready), 32'd0);
    endtask

    task automatic play4(input int r, input int c);
        int n;
        n = 0;
        while (m4.move_ready !== 1'b1 && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        m4.move_valid = 1'b1;
        m4.move_row   = 2'(r);
        m4.move_col   = 2'(c);
        @(posedge clk); #1;
        m4.move_valid = 1'b0;
        check("n4_move_ok", 32'(m4.move_ok), 32'd1);
    endtask

    initial begin : monitor
        exp_t e, pend;
        bit   have_pend;
        have_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_pend = 1'b0;
            end else begin
                if (have_pend) begin
                    check("post_turn", 32'(turn3), 32'(pend.turn));
                    check("post_winner", 32'(win3), 32'(pend.win));
                    check("post_mask", 32'(mask3), 32'(pend.mask));
                    check("post_over", 32'(over3), 32'(pend.over));
                    if (pend.ok)
                        check("post_ready", 32'(m3.move_ready),
                              32'(!pend.over));
                    have_pend = 1'b0;
                end
                if (m3.move_ok || m3.move_err) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: got ok=%b err=%b, expected none",
                                 m3.move_ok, m3.move_err);
                    end else begin
                        e = sbq.pop_front();
                        check("pulse_ok", 32'(m3.move_ok), 32'(e.ok));
                        check("pulse_err", 32'(m3.move_err), 32'(!e.ok));
                        check("board_valid", 32'(valid3), 32'(e.vld));
                        check("board_symbol", 32'(symbol3 & valid3),
                              32'(e.sym));
                        pend      = e;
                        have_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : stim
        exp_t e;
        reset         = 1'b1;
        ng3           = 1'b0;
        ng4           = 1'b0;
        m3.move_valid = 1'b0;
        m3.move_row   = '0;
        m3.move_col   = '0;
        m4.move_valid = 1'b0;
        m4.move_row   = '0;
        m4.move_col   = '0;
        model_clear();
        #12;
        check_idle("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // X takes the top row
        play(0, 0); play(1, 0); play(0, 1); play(1, 1); play(0, 2);
        @(posedge clk); #1;
        check("row_winner", 32'(win3), 32'b10);
        check("row_over", 32'(over3), 32'd1);
        check("row_mask", 32'(mask3), 32'b000000111);
        check("row_ready", 32'(m3.move_ready), 32'd0);
        check("row_pending", sbq.size(), 32'd0);
        poke(2, 2);

        // occupied cell, then a legal replay
        start_new(1'b0);
        play(0, 0); play(0, 0);
        check("occ_err", 32'(m3.move_err), 32'd1);
        check("occ_turn", 32'(turn3), 32'd0);
        check("occ_valid", 32'(valid3), 32'b000000001);
        play(2, 2);
        check("replay_ok", 32'(m3.move_ok), 32'd1);

        // out of range, then a full board with no line
        start_new(1'b0);
        play(3, 0);
        check("range_err", 32'(m3.move_err), 32'd1);
        check("range_valid", 32'(valid3), 32'd0);
        play(0, 0); play(0, 1); play(0, 2); play(1, 1); play(1, 0);
        play(1, 2); play(2, 1); play(2, 0); play(2, 2);
        @(posedge clk); #1;
        check("draw_winner", 32'(win3), 32'b11);
        check("draw_mask", 32'(mask3), 32'd0);
        check("draw_over", 32'(over3), 32'd1);
        poke(1, 1);

        // O completes the anti-diagonal
        start_new(1'b1);
        play(0, 0); play(0, 2); play(0, 1); play(1, 1); play(1, 0);
        play(2, 0);
        @(posedge clk); #1;
        check("anti_winner", 32'(win3), 32'b01);
        check("anti_mask", 32'(mask3), 32'b001010100);

        // new_game while the result is being evaluated
        start_new(1'b0);
        play(0, 0);
        wait_ready();
        e      = model_move(1, 1);
        e.turn = 1'b1;
        e.win  = 2'b00;
        e.mask = '0;
        e.over = 1'b0;
        sbq.push_back(e);
        m3.move_valid = 1'b1;
        m3.move_row   = 2'd1;
        m3.move_col   = 2'd1;
        @(posedge clk); #1;
        ng3         = 1'b1;
        m3.move_row = 2'd2;
        @(posedge clk); #1;
        ng3           = 1'b0;
        m3.move_valid = 1'b0;
        model_clear();
        check_idle("ng_check");

        // asynchronous reset in the middle of CHECK
        play(2, 2);
        #1 reset = 1'b1;
        #1;
        sbq.delete();
        model_clear();
        check_idle("async_rst");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int g = 0; g < 40; g++) begin
            start_new(1'($urandom_range(0, 1)));
            for (int k = 0; k < 40 && !m_over; k++) begin
                play($urandom_range(0, 3), $urandom_range(0, 3));
                if (last_ok && !m_over && $urandom_range(0, 3) == 0)
                    poke($urandom_range(0, 3), $urandom_range(0, 3));
                if ($urandom_range(0, 29) == 0)
                    break;
            end
            if (m_over) begin
                @(posedge clk); #1;
                check_done();
                poke($urandom_range(0, 3), $urandom_range(0, 3));
            end
        end

        // N=4: X fills column 3
        play4(0, 3); play4(0, 0); play4(1, 3); play4(1, 0);
        play4(2, 3); play4(2, 1);
        @(posedge clk); #1;
        check("n4_early_winner", 32'(win4), 32'd0);
        check("n4_early_over", 32'(over4), 32'd0);
        play4(3, 3);
        @(posedge clk); #1;
        check("n4_winner", 32'(win4), 32'b10);
        check("n4_mask", 32'(mask4), 32'h8888);
        check("n4_over", 32'(over4), 32'd1);

        @(posedge clk); #1;
        check("sb_drained", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
